// File: rtl/i2c_slave_responder.sv
// I2C target responder: oversampled and glitch-filtered SCL/SDA, START/STOP
// detection, 7-bit address match, ACKed byte writes and host-supplied byte reads.
// No clock stretching; SCL is only observed.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  S_IDLE     | bus free, waiting for START
//  S_ADDR     | shifting in address byte (7-bit address + R/W)
//  S_ADDR_ACK | address matched: drive ACK slot, then enter RX or TX
//  S_RX       | shifting in a data byte written by the master
//  S_RX_ACK   | drive ACK slot for the received byte
//  S_TX       | shifting out a read byte, one bit per SCL fall
//  S_TX_ACK   | SDA released, sample master ACK/NACK
//  S_IGNORE   | not addressed or master NACKed; wait for START/STOP
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       I_clk,
  input  logic       rst_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  output logic       rw_o,
  output logic       busy_o,
  output logic       stop_o
);

  localparam int            CW        = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [1:0]             raw;       // {sda, scl} after synchronizers
  logic [1:0]             filt;      // accepted levels
  logic [1:0]             filt_d;    // accepted levels one cycle ago
  logic [CW-1:0]          filt_cnt [2];

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] rx_byte;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       mack;

  // Metastability chains; idle bus level is high, so reset to 1
  always_ff @(posedge I_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign raw = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

  // Glitch filter: a new level is accepted after FILTER_LEN consecutive samples
  always_ff @(posedge I_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      filt        <= 2'b11;
      filt_d      <= 2'b11;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] != filt[i]) begin
          if (filt_cnt[i] == FILT_LAST) begin
            filt[i]     <= raw[i];
            filt_cnt[i] <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + CW'(1);
          end
        end else begin
          filt_cnt[i] <= '0;
        end
      end
    end
  end

  // START/STOP require SCL high on both sides of the SDA change so that a
  // simultaneous SCL/SDA transition is never misread as a bus condition.
  assign scl_rise = filt[0] & ~filt_d[0];
  assign scl_fall = ~filt[0] & filt_d[0];
  assign start_c  = filt_d[1] & ~filt[1] & filt[0] & filt_d[0];
  assign stop_c   = ~filt_d[1] & filt[1] & filt[0] & filt_d[0];
  assign rx_byte  = {shreg[6:0], filt[1]};

  // Protocol FSM with registered outputs; START/STOP override any SCL edge
  always_ff @(posedge I_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd7;
      shreg      <= '0;
      mack       <= 1'b0;
      sda_oe_o   <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      rw_o       <= 1'b0;
      busy_o     <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      stop_o     <= 1'b0;
      if (start_c) begin
        sda_oe_o <= 1'b0;
        bit_cnt  <= 3'd7;
        mack     <= 1'b0;
        state    <= S_ADDR;
      end else if (stop_c) begin
        sda_oe_o <= 1'b0;
        stop_o   <= busy_o;
        busy_o   <= 1'b0;
        mack     <= 1'b0;
        state    <= S_IDLE;
      end else begin
        case (state)
          S_ADDR: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd0) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                rw_o     <= rx_byte[0];
                busy_o   <= 1'b1;
                tx_req_o <= rx_byte[0];
                state    <= S_ADDR_ACK;
              end else begin
                busy_o <= 1'b0;
                state  <= S_IGNORE;
              end
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            bit_cnt <= 3'd7;
            if (!sda_oe_o) begin
              sda_oe_o <= 1'b1;
            end else if (rw_o) begin
              sda_oe_o <= ~tx_data_i[7];
              shreg    <= {tx_data_i[6:0], 1'b0};
              state    <= S_TX;
            end else begin
              sda_oe_o <= 1'b0;
              state    <= S_RX;
            end
          end
          S_RX: if (scl_rise) begin
            shreg <= rx_byte;
            if (bit_cnt == 3'd0) begin
              rx_data_o  <= rx_byte;
              rx_valid_o <= 1'b1;
              state      <= S_RX_ACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          S_RX_ACK: if (scl_fall) begin
            bit_cnt <= 3'd7;
            if (!sda_oe_o) begin
              sda_oe_o <= 1'b1;
            end else begin
              sda_oe_o <= 1'b0;
              state    <= S_RX;
            end
          end
          S_TX: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe_o <= 1'b0;
              bit_cnt  <= 3'd7;
              state    <= S_TX_ACK;
            end else begin
              sda_oe_o <= ~shreg[7];
              shreg    <= {shreg[6:0], 1'b0};
              bit_cnt  <= bit_cnt - 3'd1;
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (!filt[1]) begin
                mack     <= 1'b1;
                tx_req_o <= 1'b1;
              end else begin
                state <= S_IGNORE;
              end
            end else if (scl_fall && mack) begin
              mack     <= 1'b0;
              sda_oe_o <= ~tx_data_i[7];
              shreg    <= {tx_data_i[6:0], 1'b0};
              bit_cnt  <= 3'd7;
              state    <= S_TX;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
